// File: rtl/fifo_write_pointer_controller_pkg.sv
// Shared pointer helpers for the asynchronous FIFO pointer controllers.
// The write-side and read-side controllers both import this package so the
// Gray encode/decode and the full comparison are written once. All helpers
// work on a 32-bit word; callers zero-extend narrower pointers and truncate
// the result back to their own pointer width.
package fifo_write_pointer_controller_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Pointer width for a given memory address width: one extra wrap bit.
  function automatic int pointer_width(input int address_width);
    return address_width + 1;
  endfunction

  // Binary to reflected Gray code.
  function automatic ptr_word_t binary_to_gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running XOR prefix starting from the MSB.
  function automatic ptr_word_t gray_to_binary(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The Gray value a write pointer holds when it is exactly one full lap
  // ahead of the given read pointer: the top two bits inverted.
  function automatic ptr_word_t full_compare_target(input ptr_word_t rptr_gray,
                                                    input int        width);
    return rptr_gray ^ (ptr_word_t'(2'b11) << (width - 2));
  endfunction

  // True when the write Gray pointer is one full lap ahead of the read one.
  function automatic logic pointers_full(input ptr_word_t wptr_gray,
                                         input ptr_word_t rptr_gray,
                                         input int        width);
    return wptr_gray == full_compare_target(rptr_gray, width);
  endfunction

endpackage

// File: rtl/fifo_write_pointer_controller_gray_to_binary_converter.sv
// Combinational Gray-to-binary converter of configurable width.
// Each binary bit is the XOR of the Gray bits from the MSB down to itself.
module fifo_write_pointer_controller_gray_to_binary_converter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign binary[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/fifo_write_pointer_controller.sv
// Write-side pointer and flag logic of an asynchronous FIFO (write clock
// domain). Holds the binary write pointer, publishes a registered Gray copy
// for the read-domain synchronizer, and derives full / sticky overflow from
// the already-synchronized Gray read pointer.
// Optional feature: define FIFO_WRITE_POINTER_CONTROLLER_ALMOST_FULL_EN to add
// the registered almost_full output and the Gray-to-binary read pointer path.
module fifo_write_pointer_controller
  import fifo_write_pointer_controller_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = 3,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_request,
  input  logic                     overflow_clear,
  input  logic [ADDRESS_WIDTH:0]   read_pointer_gray_sync,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  output logic                     full,
`ifdef FIFO_WRITE_POINTER_CONTROLLER_ALMOST_FULL_EN
  output logic                     almost_full,
`endif
  output logic                     overflow
);

  localparam int PW    = pointer_width(ADDRESS_WIDTH);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  // Elaboration-time parameter sanity checks.
  if (ADDRESS_WIDTH < 2) begin : g_bad_address_width
    $error("ADDRESS_WIDTH must be at least 2");
  end
  if (ALMOST_FULL_MARGIN < 1 || ALMOST_FULL_MARGIN > DEPTH - 1) begin : g_bad_margin
    $error("ALMOST_FULL_MARGIN must be in 1..2**ADDRESS_WIDTH-1");
  end

  logic [PW-1:0] wptr_bin_q;
  logic [PW-1:0] wptr_bin_d;
  logic [PW-1:0] wptr_gray_q;
  logic [PW-1:0] wptr_gray_d;
  logic          full_q;
  logic          full_d;
  logic          overflow_q;
  logic          overflow_d;
  logic          accepted;
  logic          rejected;

  // A write is taken only while not full; a request while full is rejected.
  assign accepted = write_request & ~full_q;
  assign rejected = write_request & full_q;

  // Next pointer values and the full decision; full is re-evaluated every
  // cycle so it drops as soon as the synchronized read pointer moves.
  always_comb begin
    wptr_bin_d  = wptr_bin_q + PW'(accepted);
    wptr_gray_d = PW'(binary_to_gray(ptr_word_t'(wptr_bin_d)));
    full_d      = pointers_full(ptr_word_t'(wptr_gray_d),
                                ptr_word_t'(read_pointer_gray_sync), PW);
  end

  // Sticky overflow: a rejected write sets it and wins over a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clear) begin
      overflow_d = 1'b0;
    end
    if (rejected) begin
      overflow_d = 1'b1;
    end
  end

  // Pointer and flag registers; the Gray pointer must be a flop output so
  // only one bit toggles per cycle into the synchronizer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef FIFO_WRITE_POINTER_CONTROLLER_ALMOST_FULL_EN
  logic [PW-1:0] read_binary;
  logic [PW-1:0] fill;
  logic          almost_full_q;
  logic          almost_full_d;

  fifo_write_pointer_controller_gray_to_binary_converter #(
    .WIDTH (PW)
  ) u_read_pointer_decode (
    .gray   (read_pointer_gray_sync),
    .binary (read_binary)
  );

  // Occupancy after this edge; full always implies almost_full.
  always_comb begin
    fill          = wptr_bin_d - read_binary;
    almost_full_d = full_d | (fill >= PW'(DEPTH - ALMOST_FULL_MARGIN));
  end

  // Registered almost_full flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

  assign write_enable       = accepted;
  assign write_address      = wptr_bin_q[ADDRESS_WIDTH-1:0];
  assign write_pointer_gray = wptr_gray_q;
  assign full               = full_q;
  assign overflow           = overflow_q;

endmodule
